// File: rtl/posit_normalize_pipe.sv
`default_nettype none
// ============================================================================
// Module   : posit_normalize_pipe
// Purpose  : Encodes a decoded posit (sign, NaR, zero, signed scale, fraction,
//            sticky) back into a POSIT_WIDTH / POSIT_ES posit word. Rounding is
//            round-to-nearest-even. Results saturate to maxpos/minpos.
//            Three-stage pipeline: regime/exponent, assemble, round/sign.
//            All stages advance together under one valid/ready handshake.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            in_valid/in_ready - input handshake
//            sign_i, NaR_i, zero_i, scale_i, fraction_i, sticky_i - decoded value
//            out_valid/out_ready - output handshake
//            posit_word_o     - encoded posit word
// Revision : 1.0 - initial release
// ============================================================================
module posit_normalize_pipe #(
  parameter int POSIT_WIDTH       = 8,
  parameter int POSIT_ES          = 1,   // must be >= 1
  parameter int SCALE_WIDTH       = $clog2((POSIT_WIDTH-1) << POSIT_ES) + 1,
  parameter int FRACTION_IN_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         sign_i,
  input  logic                         NaR_i,
  input  logic                         zero_i,
  input  logic [SCALE_WIDTH-1:0]       scale_i,
  input  logic [FRACTION_IN_WIDTH-1:0] fraction_i,
  input  logic                         sticky_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [POSIT_WIDTH-1:0]       posit_word_o
);

  localparam int MW       = POSIT_WIDTH - 1;
  localparam int BW       = MW + POSIT_ES + FRACTION_IN_WIDTH + 2;
  localparam int PAD      = BW - 1 - POSIT_ES - FRACTION_IN_WIDTH;
  localparam int SHW      = SCALE_WIDTH + 1;
  localparam int MAXSCALE = (POSIT_WIDTH - 2) << POSIT_ES;

  localparam logic signed [SHW-1:0] MAX_S  = SHW'(MAXSCALE);
  localparam logic signed [SHW-1:0] ONE_S  = SHW'(1);
  localparam logic [MW-1:0]         MIN_MAG = MW'(1);

  // --------------------------------------------------------------------------
  // Handshake: the whole pipeline moves as one unit
  // --------------------------------------------------------------------------
  logic adv;
  logic s1_valid_q, s2_valid_q, s3_valid_q;

  assign adv       = ~s3_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_valid_q;

  // --------------------------------------------------------------------------
  // Stage 1: regime / exponent
  // --------------------------------------------------------------------------
  logic signed [SHW-1:0] scale_x;
  logic signed [SHW-1:0] k_x;
  logic signed [SHW-1:0] k_neg;
  logic signed [SHW-1:0] k_inc;
  logic [SHW-1:0]        s1_shift_d;
  logic                  s1_maxf_d, s1_minf_d, s1_pol_d;

  assign scale_x   = SHW'($signed(scale_i));
  assign k_x       = scale_x >>> POSIT_ES;
  assign k_neg     = -k_x;
  assign k_inc     = k_x + ONE_S;
  assign s1_maxf_d = (scale_x > MAX_S);
  assign s1_minf_d = (scale_x < -MAX_S);
  assign s1_pol_d  = ~k_x[SHW-1];
  // Shift is the run length minus the terminating bit: k+1 ones (k>=0) or
  // -k zeros (k<0); the terminator is seeded into the buffer below.
  assign s1_shift_d = k_x[SHW-1] ? k_neg : k_inc;

  logic                         s1_sign_q, s1_nar_q, s1_zero_q;
  logic                         s1_maxf_q, s1_minf_q, s1_pol_q, s1_sticky_q;
  logic [SHW-1:0]               s1_shift_q;
  logic [POSIT_ES-1:0]          s1_exp_q;
  logic [FRACTION_IN_WIDTH-1:0] s1_frac_q;

  // --------------------------------------------------------------------------
  // Stage 2: assemble body and split into mag / guard / sticky
  // --------------------------------------------------------------------------
  logic [BW-1:0] seed;
  logic [BW-1:0] body;
  logic [MW-1:0] s2_mag_d;
  logic          s2_guard_d, s2_sticky_d;

  // The regime terminator (opposite of the run polarity) leads the seed; the
  // shift then fills the vacated MSBs with the run polarity.
  assign seed = {~s1_pol_q, s1_exp_q, s1_frac_q, {PAD{1'b0}}};
  assign body = s1_pol_q ? ~((~seed) >> s1_shift_q) : (seed >> s1_shift_q);

  assign s2_mag_d    = body[BW-1 -: MW];
  assign s2_guard_d  = body[BW-1-MW];
  assign s2_sticky_d = (|body[BW-2-MW:0]) | s1_sticky_q;

  logic          s2_sign_q, s2_nar_q, s2_zero_q, s2_maxf_q, s2_minf_q;
  logic          s2_guard_q, s2_sticky_q;
  logic [MW-1:0] s2_mag_q;

  // --------------------------------------------------------------------------
  // Stage 3: round, saturate, apply sign
  // --------------------------------------------------------------------------
  logic                   rnd;
  logic [MW:0]            sum;
  logic [MW-1:0]          mag_f;
  logic [POSIT_WIDTH-1:0] uword;
  logic [POSIT_WIDTH-1:0] s3_word_d;
  logic [POSIT_WIDTH-1:0] s3_word_q;

  assign rnd = s2_guard_q & (s2_mag_q[0] | s2_sticky_q);
  assign sum = {1'b0, s2_mag_q} + {{MW{1'b0}}, rnd};

  always_comb begin
    mag_f = sum[MW] ? {MW{1'b1}} : sum[MW-1:0];
    // A nonzero value never rounds to zero: it becomes minpos
    if (mag_f == '0) mag_f = MIN_MAG;
    if (s2_maxf_q)      mag_f = {MW{1'b1}};
    else if (s2_minf_q) mag_f = MIN_MAG;
    uword     = {1'b0, mag_f};
    s3_word_d = s2_sign_q ? -uword : uword;
    if (s2_nar_q)       s3_word_d = {1'b1, {MW{1'b0}}};
    else if (s2_zero_q) s3_word_d = '0;
  end

  assign posit_word_o = s3_word_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_word_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s3_word_q  <= s3_word_d;
    end
  end

  // Datapath registers need no reset: qualified by the valid bits above
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q   <= sign_i;
      s1_nar_q    <= NaR_i;
      s1_zero_q   <= zero_i;
      s1_maxf_q   <= s1_maxf_d;
      s1_minf_q   <= s1_minf_d;
      s1_pol_q    <= s1_pol_d;
      s1_shift_q  <= s1_shift_d;
      s1_exp_q    <= scale_i[POSIT_ES-1:0];
      s1_frac_q   <= fraction_i;
      s1_sticky_q <= sticky_i;

      s2_sign_q   <= s1_sign_q;
      s2_nar_q    <= s1_nar_q;
      s2_zero_q   <= s1_zero_q;
      s2_maxf_q   <= s1_maxf_q;
      s2_minf_q   <= s1_minf_q;
      s2_mag_q    <= s2_mag_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_normalize_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_normalize_pipe
// Purpose  : Self-checking bench for posit_normalize_pipe (8-bit, es=1).
//            Table of directed vectors with hand-computed posit words, plus
//            backpressure and mid-stream reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_posit_normalize_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       sign_i, NaR_i, zero_i, sticky_i;
  logic [4:0] scale_i;
  logic [7:0] fraction_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] posit_word_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  posit_normalize_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign_i       (sign_i),
    .NaR_i        (NaR_i),
    .zero_i       (zero_i),
    .scale_i      (scale_i),
    .fraction_i   (fraction_i),
    .sticky_i     (sticky_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .posit_word_o (posit_word_o)
  );

  typedef struct {
    string      name;
    logic       sign;
    logic       nar;
    logic       zero;
    logic [4:0] scale;
    logic [7:0] frac;
    logic       sticky;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    sign_i     = v.sign;
    NaR_i      = v.nar;
    zero_i     = v.zero;
    scale_i    = v.scale;
    fraction_i = v.frac;
    sticky_i   = v.sticky;
  endtask

  // One isolated beat: checks 3-cycle latency and the encoded word
  task automatic run_one(input vec_t v);
    int cnt;
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({v.name, " latency"}, cnt, 3);
    check({v.name, " word"}, {24'd0, posit_word_o}, {24'd0, v.exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent, recv, extra, emitted;
    logic in_ok, out_ok;
    logic [7:0] held;

    //                 name            sg  nar zro scale    frac   stk  expected
    vecs[0]  = '{"s0",              0, 0, 0, 5'd0,    8'h00, 0, 8'h40};
    vecs[1]  = '{"s0 neg",          1, 0, 0, 5'd0,    8'h00, 0, 8'hC0};
    vecs[2]  = '{"s1",              0, 0, 0, 5'd1,    8'h00, 0, 8'h50};
    vecs[3]  = '{"s-1",             0, 0, 0, 5'h1F,   8'h00, 0, 8'h30};
    vecs[4]  = '{"tie even",        0, 0, 0, 5'd0,    8'h08, 0, 8'h40};
    vecs[5]  = '{"tie odd up",      0, 0, 0, 5'd0,    8'h18, 0, 8'h42};
    vecs[6]  = '{"sticky up",       0, 0, 0, 5'd0,    8'h08, 1, 8'h41};
    vecs[7]  = '{"s12 maxpos",      0, 0, 0, 5'd12,   8'h00, 0, 8'h7F};
    vecs[8]  = '{"s15 sat",         0, 0, 0, 5'd15,   8'h00, 0, 8'h7F};
    vecs[9]  = '{"s-12 minpos",     0, 0, 0, 5'h14,   8'h00, 0, 8'h01};
    vecs[10] = '{"s-16 sat",        0, 0, 0, 5'h10,   8'h00, 0, 8'h01};
    vecs[11] = '{"s-16 neg",        1, 0, 0, 5'h10,   8'h00, 0, 8'hFF};
    vecs[12] = '{"zero",            0, 0, 1, 5'd3,    8'h55, 1, 8'h00};
    vecs[13] = '{"NaR",             1, 1, 0, 5'($urandom), 8'($urandom), 0, 8'h80};
    vecs[14] = '{"NaR+zero",        0, 1, 1, 5'd0,    8'h00, 0, 8'h80};
    vecs[15] = '{"s2",              0, 0, 0, 5'd2,    8'h00, 0, 8'h60};
    vecs[16] = '{"s-3",             0, 0, 0, 5'h1D,   8'h00, 0, 8'h18};
    vecs[17] = '{"s12 neg",         1, 0, 0, 5'd12,   8'h00, 0, 8'h81};
    vecs[18] = '{"s11 round max",   0, 0, 0, 5'd11,   8'hFF, 0, 8'h7F};
    vecs[19] = '{"s6 frac",         0, 0, 0, 5'd6,    8'h80, 0, 8'h79};
    vecs[20] = '{"carry to exp",    0, 0, 0, 5'd0,    8'hF8, 0, 8'h50};

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check("reset out_valid", {31'd0, out_valid}, 0);
    check("reset word",      {24'd0, posit_word_o}, 0);
    check("reset in_ready",  {31'd0, in_ready}, 1);

    // Directed table
    for (int i = 0; i < NV; i++) run_one(vecs[i]);
    @(posedge clk); #1;

    // Streaming with a 4-cycle output stall
    sent = 0; recv = 0; held = '0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (sent < 6) begin
        drive(vecs[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c <= 7) begin
        check($sformatf("stall in_ready c%0d", c), {31'd0, in_ready}, 0);
        if (c == 4) held = posit_word_o;
        else check($sformatf("stall hold c%0d", c), {24'd0, posit_word_o}, {24'd0, held});
      end
      in_ok  = in_valid & in_ready;
      out_ok = out_valid & out_ready;
      if (out_ok) begin
        check($sformatf("stream beat %0d", recv), {24'd0, posit_word_o}, {24'd0, vecs[recv].exp});
        recv++;
      end
      @(posedge clk); #1;
      if (in_ok) sent++;
    end
    check("stream received", recv, 6);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      #1;
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    check("stream no duplicate", extra, 0);

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(vecs[b + 2]);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst out_valid", {31'd0, out_valid}, 0);
    check("midrst word",      {24'd0, posit_word_o}, 0);
    out_ready = 1'b1;
    emitted = 0;
    repeat (6) begin
      #1;
      if (out_valid) emitted++;
      @(posedge clk); #1;
    end
    check("midrst none emitted", emitted, 0);
    run_one(vecs[7]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/posit_normalize_pipe.md
Name: posit_normalize_pipe

Overview:
- Downstream inverse of the posit decode stage. Takes a decoded posit (sign, NaR, zero, signed scale, wide fraction, sticky) and encodes it back into a POSIT_WIDTH/POSIT_ES posit word.
- Encoding uses round-to-nearest-even and saturates to maxpos/minpos.
- 3-stage pipeline with valid/ready handshake. It sits at the output of arithmetic units (multiplier, quire readout) that produce unrounded results.

Parameters:
- POSIT_WIDTH, 8: posit word width.
- POSIT_ES, 1: exponent field width.
- SCALE_WIDTH, GET_SCALE_WIDTH(POSIT_WIDTH, POSIT_ES, 0) (=5 for default): signed scale width.
- FRACTION_IN_WIDTH, 8: input fraction bits, hidden bit excluded, MSB-aligned.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block accepts beat.
- sign_i, input, 1: sign of value.
- NaR_i, input, 1: input is NaR.
- zero_i, input, 1: input is zero.
- scale_i, input, SCALE_WIDTH: signed two's-complement scale (2^scale).
- fraction_i, input, FRACTION_IN_WIDTH: fraction bits after hidden 1.
- sticky_i, input, 1: OR of any discarded bits below fraction_i.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: consumer accepts beat.
- posit_word_o, output, POSIT_WIDTH: encoded posit.

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Reset: all stage valid bits clear. out_valid=0, posit_word_o=0, in_ready=1 in the cycle after rst is sampled high. A reset mid-operation discards all in-flight beats; no partial output.
- Handshake: transfer when valid&ready on the same edge.
  - Pipeline advances as one unit: adv = ~out_valid | out_ready; in_ready = adv.
  - While adv=0 every stage register holds and posit_word_o stays stable.
  - Bubbles propagate as valid=0 beats.
- Latency: exactly 3 cycles from input acceptance to out_valid with no stall. Full throughput of 1 beat/cycle.
- Stage 1, regime/exponent:
  - k = scale_i >>> POSIT_ES (arithmetic shift); e = scale_i[POSIT_ES-1:0].
  - Clamp: scale_i > maxscale = (POSIT_WIDTH-2)*2^POSIT_ES saturates to maxpos flag. scale_i < -maxscale saturates to minpos flag.
  - Regime run length: r = k+2 bits (k+1 ones then 0) for k>=0; r = -k+1 bits (-k zeros then 1) for k<0.
  - Register sign, NaR, zero, flags, r, regime polarity, e, fraction, sticky.
- Stage 2, assemble:
  - Build unsigned body = {regime, e, fraction_i} left-aligned in a buffer of (POSIT_WIDTH-1)+POSIT_ES+FRACTION_IN_WIDTH+2 bits via a barrel shift by r.
  - Extract top POSIT_WIDTH-1 bits as mag, next bit as guard.
  - sticky = OR(remaining bits) | sticky_i.
- Stage 3, round/sign:
  - Round up iff guard & (lsb(mag) | sticky). mag+round never exceeds all-ones; clamp to all-ones (maxpos).
  - A nonzero, non-NaR result with mag=0 becomes minpos (mag=1).
  - Word = {0, mag}; if sign, output the two's complement of the full word.
- Specials have precedence: NaR_i -> 1 followed by zeros (0x80) regardless of other inputs. Otherwise zero_i -> all zeros. NaR_i and zero_i both set -> NaR.
- Saturation flags override rounding: maxpos = 0x7F pattern, minpos = 0x01 pattern, then sign applied.
- Width rules: all internal shifts are unsigned on the buffer. scale compare is signed.

Test Plan (defaults: 8-bit, es=1):
- Reset, then scale=0, fraction=0x00, sign=0 -> 0x40 exactly 3 cycles after acceptance. Same with sign=1 -> 0xC0. scale=1 -> 0x50. scale=-1 -> 0x30.
- Rounding at scale=0:
  - fraction=0x08, sticky=0 -> 0x40 (tie, even).
  - fraction=0x18, sticky=0 -> 0x42 (tie, odd up).
  - fraction=0x08, sticky=1 -> 0x41.
- Extremes:
  - scale=12 -> 0x7F; scale=15 -> 0x7F (saturate).
  - scale=-12 -> 0x01; scale=-16 -> 0x01.
  - scale=-16, sign=1 -> 0xFF.
- Specials: zero_i=1 -> 0x00; NaR_i=1 (scale/fraction random) -> 0x80; both set -> 0x80.
- Backpressure: stream 6 beats, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the stall, posit_word_o stable, no beat lost or duplicated, output order preserved.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 the next cycle, none of those beats ever emitted. The first post-reset beat appears after 3 cycles.
